pc_unit: RTL
============

# pc_unit

Program-counter stage of the single-cycle MIPS core. It holds the fetch address that drives the instruction memory and computes next-PC for sequential, branch, j/jal and jr flow. It adds a run/halt/single-step debug FSM, a retired-instruction counter and a sticky misaligned-jr trap, so board bring-up can freeze or step the processor without touching the datapath.

## Interface

Parameters:
- `RESET_PC`, default 32'h0040_0000: PC value loaded on reset (program text base).
- `CNT_W`, default 32: width of the retired-instruction counter.
- `START_HALTED`, default 0: 1 means the FSM leaves reset in HALT instead of RUN.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `instruction`, in, 32: current instruction word from instruction memory, addressed by `pc`.
- `pc_src`, in, 2: 00 sequential, 01 conditional branch, 10 j/jal, 11 jr.
- `branch_taken`, in, 1: branch condition from control/ALU. Only meaningful when `pc_src`=01.
- `jr_target`, in, 32: rs register value for jr.
- `run_req`, in, 1: level request to leave HALT and free-run.
- `step_req`, in, 1: level request to execute exactly one instruction from HALT.
- `halt_req`, in, 1: request to stop after the current instruction.
- `pc`, out, 32: current fetch address.
- `pc_plus4`, out, 32: combinational `pc`+4 (jal link value).
- `commit`, out, 1: combinational. High when the current instruction's state updates must be written this cycle. It gates RegWrite and MemWrite downstream.
- `halted`, out, 1: high when the FSM is in HALT.
- `retired`, out, CNT_W: count of committed instructions.
- `misalign`, out, 1: sticky flag set by a misaligned jr target.

## Operation

- Next-PC selection, with all arithmetic modulo 2^32:
  - 00: `pc`+4.
  - 01: if `branch_taken`, `pc`+4 + (sign-extended `instruction[15:0]` << 2); otherwise `pc`+4.
  - 10: {`pc_plus4[31:28]`, `instruction[25:0]`, 2'b00}.
  - 11: `jr_target`.
- FSM states are RUN, HALT and STEP.
- `commit` = (state is RUN or STEP) and not `trap`, where `trap` = (`pc_src`=11 and `jr_target[1:0]`≠0).
- On a rising edge with `commit`=1: `pc` ← next-PC and `retired` ← `retired`+1, wrapping to 0 at 2^CNT_W.
- On a rising edge with state RUN or STEP and `trap`=1:
  - `pc` holds.
  - `misalign` ← 1.
  - `retired` holds.
  - State goes to HALT.
- Transitions (when no trap occurs):
  - RUN → HALT if `halt_req`=1. The instruction executing at that edge still commits. Otherwise RUN → RUN.
  - STEP → HALT unconditionally after its one commit. `halt_req`, `run_req` and `step_req` are ignored in STEP.
  - HALT → RUN if `run_req`=1. Otherwise HALT → STEP if `step_req`=1. Otherwise stay in HALT. `run_req` has priority over `step_req`.
  - While `misalign`=1, HALT ignores `run_req` and `step_req`. Only reset clears the flag.
- Requests are level-sensitive. A held `step_req` alternates HALT and STEP, committing one instruction every 2 cycles.
- The jump-to-self loop `pc_src`=10 with target equal to `pc` is legal. `pc` stays constant and `retired` keeps counting.

## Timing

- Reset (`rst_n` low, asynchronous, immediate):
  - `pc`=RESET_PC.
  - `retired`=0.
  - `misalign`=0.
  - State = HALT if START_HALTED=1, else RUN.
  - `halted` follows state, so it is 0 with the default START_HALTED.
- Reset deassertion takes effect at the first rising edge after `rst_n` goes high. Asserting reset mid-instruction abandons that instruction; no partial commit occurs.
- `pc`, `halted`, `retired` and `misalign` are registered.
- `pc_plus4` and `commit` are combinational from `pc`, state and the inputs in the same cycle.
- Fetch-to-next-PC latency is one cycle: the next-PC value computed in cycle k appears on `pc` in cycle k+1.
- After `run_req` or `step_req` is sampled in HALT, `commit` goes high in the following cycle.
- After `halt_req` is sampled in RUN, `halted` rises in the next cycle, and exactly one instruction has committed at that edge.

## Test plan

- **Reset and sequential flow.** Release reset with `pc_src`=00 for 3 cycles. `pc` is 0x00400000, then 0x00400004, 0x00400008, 0x0040000C. `retired`=3.
- **Forward and backward branches.**
  - At `pc`=0x0040001C, instruction 0x112a0022, `pc_src`=01, `branch_taken`=1 → next `pc`=0x004000A8.
  - At 0x00400184, instruction 0x170fffce, taken → 0x004000C0.
  - Same instruction with `branch_taken`=0 → 0x00400188.
- **Jumps.**
  - At 0x00400054, instruction 0x0810000c, `pc_src`=10 → 0x00400030.
  - At 0x004002B8, instruction 0x081000ae → `pc` stays at 0x004002B8 while `retired` increments every cycle.
- **Misaligned jr and recovery.**
  - `pc_src`=11 with `jr_target`=0x00400003 → `pc` holds, `misalign`=1 and `halted`=1 next cycle, `commit`=0 in the trap cycle.
  - `run_req`=1 afterwards has no effect.
  - Pulsing `rst_n` low clears the flag.
  - A second case with `jr_target`=0x00400040 → `pc`=0x00400040.
- **Halt/step/run.**
  - `halt_req` high for 1 cycle in RUN → one more commit, then `halted`=1 and `pc` frozen for 10 cycles.
  - `step_req` held 6 cycles → exactly 3 commits, `pc` advances by 12.
  - `run_req` and `step_req` high together → RUN.
- **Counter wrap.** With CNT_W=4, 17 commits from reset → `retired`=1.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter stage of the single-cycle MIPS core.
// Next-PC selection with a run/halt/step debug FSM, retire counter and jr trap.
module pc_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0040_0000,
    parameter int          CNT_W        = 32,
    parameter bit          START_HALTED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instruction,
    input  logic [1:0]       pc_src,
    input  logic             branch_taken,
    input  logic [31:0]      jr_target,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             halt_req,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             commit,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    output logic             misalign
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam state_t RST_STATE = START_HALTED ? HALT : RUN;

    state_t      state;
    state_t      state_n;
    logic [31:0] next_pc;
    logic [31:0] br_off;
    logic        active;
    logic        trap;
    logic        unused_opcode;

    // opcode field is decoded by control, not here
    assign unused_opcode = ^instruction[31:26];

    assign pc_plus4 = pc + 32'd4;
    assign br_off   = {{14{instruction[15]}}, instruction[15:0], 2'b00};
    assign active   = (state == RUN) || (state == STEP);
    assign trap     = (pc_src == 2'b11) && (jr_target[1:0] != 2'b00);
    assign commit   = active && !trap;
    assign halted   = (state == HALT);

    always_comb begin
        next_pc = pc_plus4;
        unique case (pc_src)
            2'b00: next_pc = pc_plus4;
            2'b01: next_pc = branch_taken ? (pc_plus4 + br_off) : pc_plus4;
            2'b10: next_pc = {pc_plus4[31:28], instruction[25:0], 2'b00};
            2'b11: next_pc = jr_target;
            default: next_pc = pc_plus4;
        endcase
    end

    always_comb begin
        state_n = state;
        unique case (state)
            RUN: begin
                if (trap || halt_req) begin
                    state_n = HALT;
                end
            end
            STEP: state_n = HALT;
            HALT: begin
                // a latched trap locks the core until reset
                if (!misalign) begin
                    if (run_req) begin
                        state_n = RUN;
                    end else if (step_req) begin
                        state_n = STEP;
                    end
                end
            end
            default: state_n = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_STATE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            retired <= '0;
        end else if (commit) begin
            pc      <= next_pc;
            retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign <= 1'b0;
        end else if (active && trap) begin
            misalign <= 1'b1;
        end
    end

endmodule
